// File: rtl/uart_rx_frame_counter.sv
// Edge/bit timing engine for the UART receiver: counts oversampling edges per bit
// and bits per frame, and decodes sample strobes plus bit/frame completion pulses.
module uart_rx_frame_counter #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               par_en,
    input  logic               stop2,
    input  logic [PRESC_W-1:0] prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               sample_stb,
    output logic [1:0]         sample_idx,
    output logic               bit_done,
    output logic               frame_done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [3:0]         bit_q, bit_d;
    logic [PRESC_W-1:0] p_q, p_d;
    logic [3:0]         n_q, n_d;
    logic               cfg_err_q, cfg_err_d;

    logic               presc_ok;
    logic [3:0]         n_calc;
    logic               last_edge;
    logic               last_bit;
    logic               in_count;
    logic [PRESC_W-1:0] mid;

    // Start + data + optional parity + one or two stop bits.
    assign n_calc    = 4'(DATA_W + 2) + {3'b000, par_en} + {3'b000, stop2};
    assign presc_ok  = (prescale >= PRESC_W'(4));
    assign last_edge = (edge_q == p_q - PRESC_W'(1));
    assign last_bit  = (bit_q == n_q - 4'd1);
    assign in_count  = (state_q == ST_COUNT);
    assign mid       = p_q >> 1;

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        n_d       = n_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (enable) begin
                    if (presc_ok) begin
                        state_d = ST_COUNT;
                        p_d     = prescale;
                        n_d     = n_calc;
                    end else begin
                        state_d   = ST_ERR;
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_COUNT: begin
                // A dropped enable wins over any wrap on the same edge.
                if (!enable) begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (last_edge) begin
                    edge_d = '0;
                    if (last_bit) begin
                        bit_d = '0;
                        if (presc_ok) begin
                            p_d = prescale;
                            n_d = n_calc;
                        end else begin
                            state_d   = ST_ERR;
                            cfg_err_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    edge_d = edge_q + PRESC_W'(1);
                end
            end
            ST_ERR: begin
                edge_d = '0;
                bit_d  = '0;
                if (!enable) begin
                    state_d   = ST_IDLE;
                    cfg_err_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                edge_d    = '0;
                bit_d     = '0;
                cfg_err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= '0;
            n_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            n_q       <= n_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Three sample points centred on floor(P/2); legal P >= 4 keeps them inside the bit.
    always_comb begin
        sample_stb = 1'b0;
        sample_idx = 2'd0;
        if (in_count) begin
            if (edge_q == mid - PRESC_W'(1)) begin
                sample_stb = 1'b1;
                sample_idx = 2'd0;
            end else if (edge_q == mid) begin
                sample_stb = 1'b1;
                sample_idx = 2'd1;
            end else if (edge_q == mid + PRESC_W'(1)) begin
                sample_stb = 1'b1;
                sample_idx = 2'd2;
            end
        end
    end

    assign edge_cnt   = edge_q;
    assign bit_cnt    = bit_q;
    assign bit_done   = in_count && last_edge;
    assign frame_done = bit_done && last_bit;
    assign cfg_err    = cfg_err_q;

endmodule
